dmem_wb_responder: RTL and testbench

- Data-memory responder for the core's data port (`clk`, `rst_n`, `d_mem_we`, `d_mem_addr`, `d_mem_data`); replaces the zero-latency data side of the external memory.
- Core writes are posted into a small write buffer and drained one per cycle into a single-port 64 x 64-bit backing array.
- Core reads are combinational, with forwarding from the buffer so the core never sees stale data.
- A registered debug read port lets the testbench inspect memory coherently; it competes with the drain for the array port.

---
 rtl/dmem_wb_responder.sv | 182 ++++++++++++++++++
 tb/tb_dmem_wb_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wb_responder.sv
// rtl/dmem_wb_responder.sv - posted-write data-memory responder with a forwarding write buffer
//
// Purpose:
//   Serves the core's data port. Core writes are posted into a DEPTH-entry
//   FIFO write buffer and drained one per cycle into a 2**AW x DW array.
//   Core reads are combinational and forward from the newest matching buffer
//   entry. A registered debug read port shares the array port with the drain
//   and stalls the drain in any cycle it is requested.
//
// Optional feature macro: DMEM_WB_STATS_EN (adds stat_writes, stat_coalesce,
//   stat_stalls saturating 16-bit counters).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   d_mem_we     core write enable
//   d_mem_addr   core word address
//   d_mem_data   bidirectional core data (driven here only while d_mem_we=0)
//   dbg_re       debug read request
//   dbg_addr     debug read address
//   dbg_rdata    registered debug read data
//   dbg_rvalid   one-cycle pulse, dbg_rdata valid
//   wb_count     occupied buffer entries (registered)
//   wb_full      wb_count == DEPTH (registered)
//   wb_overflow  sticky, a core write was dropped
module dmem_wb_responder #(
   parameter int DEPTH = 4,
   parameter int AW    = 6,
   parameter int DW    = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          d_mem_we,
   input  logic [AW-1:0] d_mem_addr,
   inout  wire  [DW-1:0] d_mem_data,
   input  logic          dbg_re,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_rvalid,
   output logic [3:0]    wb_count,
   output logic          wb_full,
   output logic          wb_overflow
`ifdef DMEM_WB_STATS_EN
   ,
   output logic [15:0]   stat_writes,
   output logic [15:0]   stat_coalesce,
   output logic [15:0]   stat_stalls
`endif
);

   localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);
   localparam int         WORDS   = 1 << AW;

   logic [DW-1:0] mem_q      [WORDS];
   logic [AW-1:0] ent_addr_q [DEPTH];
   logic [DW-1:0] ent_data_q [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [3:0]    count_q, count_d;
   logic          full_q, full_d;
   logic          ovf_q, ovf_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic          drain;
   logic          coal;
   logic          enq;
   logic [PW-1:0] coal_idx;
   logic [DW-1:0] core_rdata;
   logic [DW-1:0] dbg_fwd;

   // Forwarding scan runs oldest to newest so the newest matching entry wins.
   always_comb begin
      core_rdata = mem_q[d_mem_addr];
      dbg_fwd    = mem_q[dbg_addr];
      for (int k = 0; k < DEPTH; k++) begin
         if (4'(k) < count_q) begin
            if (ent_addr_q[head_q + PW'(k)] == d_mem_addr) begin
               core_rdata = ent_data_q[head_q + PW'(k)];
            end
            if (ent_addr_q[head_q + PW'(k)] == dbg_addr) begin
               dbg_fwd = ent_data_q[head_q + PW'(k)];
            end
         end
      end
   end

   assign d_mem_data = d_mem_we ? {DW{1'bz}} : core_rdata;

   // Write-side decisions. The head is excluded from coalescing when it
   // leaves this cycle, so its old data still reaches the array and the new
   // write becomes a fresh entry.
   always_comb begin
      drain    = (count_q != 4'd0) && !dbg_re;
      coal     = 1'b0;
      coal_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (d_mem_we && (4'(k) < count_q) &&
             (ent_addr_q[head_q + PW'(k)] == d_mem_addr) && !(k == 0 && drain)) begin
            coal     = 1'b1;
            coal_idx = head_q + PW'(k);
         end
      end
      enq      = d_mem_we && !coal && ((count_q - {3'b000, drain}) < DEPTH_C);
      ovf_d    = ovf_q | (d_mem_we && !coal && !enq);
      count_d  = count_q - {3'b000, drain} + {3'b000, enq};
      full_d   = (count_d == DEPTH_C);
      head_d   = drain ? head_q + PW'(1) : head_q;
      tail_d   = enq ? tail_q + PW'(1) : tail_q;
      rvalid_d = dbg_re;
      rdata_d  = dbg_re ? dbg_fwd : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= 4'd0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   // Entry payloads and the array carry no reset; validity lives in count_q.
   always_ff @(posedge clk) begin
      if (coal) begin
         ent_data_q[coal_idx] <= d_mem_data;
      end
      if (enq) begin
         ent_addr_q[tail_q] <= d_mem_addr;
         ent_data_q[tail_q] <= d_mem_data;
      end
      if (drain) begin
         mem_q[ent_addr_q[head_q]] <= ent_data_q[head_q];
      end
   end

   assign dbg_rdata   = rdata_q;
   assign dbg_rvalid  = rvalid_q;
   assign wb_count    = count_q;
   assign wb_full     = full_q;
   assign wb_overflow = ovf_q;

`ifdef DMEM_WB_STATS_EN
   logic [15:0] st_wr_q, st_co_q, st_st_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_wr_q <= 16'd0;
         st_co_q <= 16'd0;
         st_st_q <= 16'd0;
      end else begin
         if ((coal || enq) && (st_wr_q != 16'hFFFF)) begin
            st_wr_q <= st_wr_q + 16'd1;
         end
         if (coal && (st_co_q != 16'hFFFF)) begin
            st_co_q <= st_co_q + 16'd1;
         end
         if ((count_q != 4'd0) && dbg_re && (st_st_q != 16'hFFFF)) begin
            st_st_q <= st_st_q + 16'd1;
         end
      end
   end

   assign stat_writes   = st_wr_q;
   assign stat_coalesce = st_co_q;
   assign stat_stalls   = st_st_q;
`endif

endmodule

// File: tb/tb_dmem_wb_responder.sv
// tb/tb_dmem_wb_responder.sv - scoreboard bench for dmem_wb_responder
module tb_dmem_wb_responder;
   localparam int DEPTH = 4;
   localparam int AW    = 6;
   localparam int DW    = 64;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b1;
   logic          tb_we    = 1'b0;
   logic [AW-1:0] tb_addr  = '0;
   logic [DW-1:0] tb_wdata = '0;
   logic          tb_dre   = 1'b0;
   logic [AW-1:0] tb_daddr = '0;
   wire  [DW-1:0] d_mem_data;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_rvalid;
   logic [3:0]    wb_count;
   logic          wb_full;
   logic          wb_overflow;
`ifdef DMEM_WB_STATS_EN
   logic [15:0]   stat_writes, stat_coalesce, stat_stalls;
`endif

   assign d_mem_data = tb_we ? tb_wdata : {DW{1'bz}};

   dmem_wb_responder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_mem_we   (tb_we),
      .d_mem_addr (tb_addr),
      .d_mem_data (d_mem_data),
      .dbg_re     (tb_dre),
      .dbg_addr   (tb_daddr),
      .dbg_rdata  (dbg_rdata),
      .dbg_rvalid (dbg_rvalid),
      .wb_count   (wb_count),
      .wb_full    (wb_full),
      .wb_overflow(wb_overflow)
`ifdef DMEM_WB_STATS_EN
      ,
      .stat_writes  (stat_writes),
      .stat_coalesce(stat_coalesce),
      .stat_stalls  (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: buffer as a queue of pending writes, array as plain memory.
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } ent_t;
   typedef struct { int gen; bit known; logic [DW-1:0] data; } dexp_t;
   typedef struct { int kind; logic [DW-1:0] val; } chk_t;

   ent_t          m_q[$];
   logic [DW-1:0] m_mem [64];
   bit            m_known [64];
   bit            m_ovf = 1'b0;
   dexp_t         dq[$];
   chk_t          cq[$];
   int            gen  = 0;
   bit            done = 1'b0;
   int            n_vec = 0;
   int            n_err = 0;

   function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] a, output bit known);
      for (int i = m_q.size() - 1; i >= 0; i--) begin
         if (m_q[i].addr == a) begin
            known = 1'b1;
            return m_q[i].data;
         end
      end
      known = m_known[a];
      return m_mem[a];
   endfunction

   task automatic m_step(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit dre, input logic [AW-1:0] da);
      bit    drn;
      int    j;
      bit    kn;
      dexp_t e;
      ent_t  n;
      if (dre) begin
         e.gen   = gen;
         e.data  = m_fwd(da, kn);
         e.known = kn;
         dq.push_back(e);
      end
      drn = (m_q.size() > 0) && !dre;
      if (we) begin
         j = -1;
         for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i].addr == a && !(i == 0 && drn)) j = i;
         end
         if (j >= 0) begin
            m_q[j].data = d;
         end else if (m_q.size() - int'(drn) < DEPTH) begin
            n.addr = a;
            n.data = d;
            m_q.push_back(n);
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (drn) begin
         m_mem[m_q[0].addr]   = m_q[0].data;
         m_known[m_q[0].addr] = 1'b1;
         void'(m_q.pop_front());
      end
   endtask

   task automatic cycle(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit dre, input logic [AW-1:0] da);
      tb_we    = we;
      tb_addr  = a;
      tb_wdata = d;
      tb_dre   = dre;
      tb_daddr = da;
      @(posedge clk);
      m_step(we, a, d, dre, da);
      #1;
   endtask

   // Expectations queued here are checked in the middle of the next cycle():
   // status kinds against state after the previous edge, kind 3 against that
   // cycle's core read.
   task automatic expect_next(input int kind, input logic [DW-1:0] v);
      chk_t c;
      c.kind = kind;
      c.val  = v;
      cq.push_back(c);
   endtask

   task automatic async_reset();
      #1 rst_n = 1'b0;
      m_q.delete();
      m_ovf = 1'b0;
      gen++;
      #2 rst_n = 1'b1;
   endtask

   function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endfunction

   initial begin : monitor
      int            rd;
      int            ci;
      bit            kn;
      logic [DW-1:0] ev;
      rd = 0;
      ci = 0;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            #1;
            chk("reset_count",  DW'(wb_count),    '0);
            chk("reset_full",   DW'(wb_full),     '0);
            chk("reset_ovf",    DW'(wb_overflow), '0);
            chk("reset_rvalid", DW'(dbg_rvalid),  '0);
            chk("reset_rdata",  dbg_rdata,        '0);
         end else begin
            chk("wb_count",    DW'(wb_count),    DW'(m_q.size()));
            chk("wb_full",     DW'(wb_full),     DW'(m_q.size() == DEPTH));
            chk("wb_overflow", DW'(wb_overflow), DW'(m_ovf));
            if (!tb_we) begin
               ev = m_fwd(tb_addr, kn);
               if (kn) chk("core_read", d_mem_data, ev);
            end
            if (dbg_rvalid) begin
               while (rd < dq.size() && dq[rd].gen != gen) rd++;
               if (rd >= dq.size()) begin
                  chk("dbg_unexpected_rvalid", DW'(1), DW'(0));
               end else begin
                  if (dq[rd].known) chk("dbg_rdata", dbg_rdata, dq[rd].data);
                  rd++;
               end
            end
            while (ci < cq.size()) begin
               case (cq[ci].kind)
                  0:       chk("dir_count",     DW'(wb_count),    cq[ci].val);
                  1:       chk("dir_full",      DW'(wb_full),     cq[ci].val);
                  2:       chk("dir_overflow",  DW'(wb_overflow), cq[ci].val);
                  default: chk("dir_core_read", d_mem_data,       cq[ci].val);
               endcase
               ci++;
            end
            if (done) break;
         end
      end
      while (rd < dq.size() && dq[rd].gen != gen) rd++;
      chk("dbg_missing_rvalid", DW'(dq.size() - rd), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL timeout: run did not complete, required completion");
      $fatal(1);
   end

   initial begin : driver
      int            burst;
      bit            we;
      bit            dre;
      logic [AW-1:0] a;
      logic [AW-1:0] da;
      burst = 0;
      #1 rst_n = 1'b0;
      #20 rst_n = 1'b1;

      // Give every array word a known value.
      for (int i = 0; i < 64; i++) cycle(1'b1, AW'(i), {$urandom, $urandom}, 1'b0, '0);
      repeat (3) cycle(1'b0, '0, '0, 1'b0, '0);

      // Write then forwarded read, then drain and read back from the array.
      cycle(1'b1, 6'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, '0);
      expect_next(0, 64'd1);
      expect_next(3, 64'hDEAD_BEEF_0000_0001);
      cycle(1'b0, 6'd5, '0, 1'b0, '0);
      expect_next(0, 64'd0);
      cycle(1'b0, '0, '0, 1'b1, 6'd5);

      // Coalesce under a debug stall.
      cycle(1'b1, 6'd3, 64'h11, 1'b1, '0);
      cycle(1'b1, 6'd3, 64'h22, 1'b1, '0);
      expect_next(0, 64'd1);
      expect_next(3, 64'h22);
      cycle(1'b0, 6'd3, '0, 1'b1, 6'd3);
      cycle(1'b0, 6'd3, '0, 1'b0, '0);
      expect_next(0, 64'd0);
      cycle(1'b0, '0, '0, 1'b1, 6'd3);

      // Overflow while the drain is held off.
      for (int i = 0; i < 4; i++) cycle(1'b1, AW'(i), 64'h100 + 64'(i), 1'b1, '0);
      expect_next(0, 64'd4);
      expect_next(1, 64'd1);
      expect_next(2, 64'd0);
      cycle(1'b1, 6'd4, 64'hBAD, 1'b1, '0);
      expect_next(0, 64'd4);
      expect_next(2, 64'd1);
      cycle(1'b0, 6'd4, '0, 1'b1, 6'd4);
      repeat (5) cycle(1'b0, '0, '0, 1'b0, '0);

      // Full buffer that drains in the same cycle still accepts a write.
      async_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, AW'(8 + i), 64'h200 + 64'(i), 1'b1, '0);
      expect_next(0, 64'd4);
      expect_next(1, 64'd1);
      cycle(1'b1, 6'd12, 64'hC0FFEE, 1'b0, '0);
      expect_next(0, 64'd4);
      expect_next(2, 64'd0);
      expect_next(3, 64'hC0FFEE);
      cycle(1'b0, 6'd12, '0, 1'b0, '0);
      repeat (5) cycle(1'b0, '0, '0, 1'b0, '0);

      // Head-drain race: old head data drains, new write becomes a new entry.
      cycle(1'b1, 6'd7, 64'hA, 1'b0, '0);
      expect_next(0, 64'd1);
      cycle(1'b1, 6'd7, 64'hB, 1'b0, '0);
      expect_next(0, 64'd1);
      expect_next(3, 64'hB);
      cycle(1'b0, 6'd7, '0, 1'b1, 6'd7);
      cycle(1'b0, 6'd7, '0, 1'b0, '0);
      cycle(1'b0, '0, '0, 1'b1, 6'd7);

      // Async reset with entries pending and a debug read in flight.
      cycle(1'b1, 6'd20, 64'h300, 1'b1, '0);
      cycle(1'b1, 6'd21, 64'h301, 1'b1, '0);
      cycle(1'b1, 6'd22, 64'h302, 1'b1, '0);
      expect_next(0, 64'd3);
      cycle(1'b0, '0, '0, 1'b1, '0);
      async_reset();
      expect_next(0, 64'd0);
      cycle(1'b0, 6'd20, '0, 1'b1, 6'd20);
      cycle(1'b0, 6'd21, '0, 1'b0, '0);

      // Randomised traffic on a small address set to provoke coalescing and overflow.
      for (int n = 0; n < 1500; n++) begin
         if (n % 400 == 399) async_reset();
         if (burst == 0 && $urandom_range(0, 11) == 0) burst = $urandom_range(1, 8);
         dre = (burst > 0) || ($urandom_range(0, 9) == 0);
         if (burst > 0) burst--;
         we = ($urandom_range(0, 1) == 1);
         a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
         da = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
         cycle(we, a, {$urandom, $urandom}, dre, da);
      end
      repeat (8) cycle(1'b0, '0, '0, 1'b0, '0);
      done = 1'b1;
   end

endmodule
